// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: bit order, hex glyph codes and the dark pattern.
// Active-low segments; bit7 = a ... bit1 = g, bit0 = dp.
package seg_pkg;

  typedef struct packed {
    logic [6:0] abcdefg;
    logic       dp;
  } seg_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

  function automatic seg_t seg_pack(input logic [6:0] abcdefg, input logic dp_n);
    seg_t s;
    s.abcdefg = abcdefg;
    s.dp      = dp_n;
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the scan controller: frame contents and controls in, LED drive out.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                      enable;
  logic [4*NUM_DIGITS-1:0]   display;
  logic [NUM_DIGITS-1:0]     dp;
  logic [NUM_DIGITS-1:0]     blank_mask;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic [2:0]                brightness;
  logic [NUM_DIGITS-1:0]     led_en;
  logic [7:0]                led_cx;
  logic                      frame_done;

  modport master (
    output enable, display, dp, blank_mask, blink_mask, brightness,
    input  led_en, led_cx, frame_done
  );

  modport slave (
    input  enable, display, dp, blank_mask, blink_mask, brightness,
    output led_en, led_cx, frame_done
  );
endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low {a..g} glyph lookup; zero latency.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_HEX_0;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with PWM brightness, per-digit blank/blink and frame shadowing.
// Outputs are registered one cycle after the counter/index state that selects them.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_PERIOD = 100000,
  parameter int BLINK_HALF  = 25000000
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int SUB_LEN = SCAN_PERIOD / 8;
  localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int SW = (SUB_LEN > 1)     ? $clog2(SUB_LEN)     : 1;
  localparam int IW = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
  localparam int BW = (BLINK_HALF > 1)  ? $clog2(BLINK_HALF)  : 1;

  logic [CW-1:0] slot_cnt;
  logic [SW-1:0] sub_cnt;
  logic [2:0]    sub_phase;
  logic [IW-1:0] idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [NUM_DIGITS-1:0][3:0] disp_sh;
  logic [NUM_DIGITS-1:0]      dp_sh;
  logic [NUM_DIGITS-1:0]      blank_sh;
  logic [NUM_DIGITS-1:0]      blink_sh;

  logic                  slot_tick;
  logic                  last_digit;
  logic                  lit;
  logic [6:0]            hex_seg;
  logic [NUM_DIGITS-1:0] en_nxt;
  seg_t                  cx_nxt;

  assign slot_tick  = (slot_cnt == CW'(SCAN_PERIOD - 1));
  assign last_digit = (idx == IW'(NUM_DIGITS - 1));

  // sub_cnt/sub_phase track slot_cnt / SUB_LEN incrementally, avoiding a divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt  <= '0;
      sub_cnt   <= '0;
      sub_phase <= '0;
    end else if (slot_tick) begin
      slot_cnt  <= '0;
      sub_cnt   <= '0;
      sub_phase <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (sub_cnt == SW'(SUB_LEN - 1)) begin
        sub_cnt   <= '0;
        sub_phase <= sub_phase + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      disp_sh  <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
      blink_sh <= '0;
    end else if (slot_tick) begin
      if (last_digit) begin
        idx      <= '0;
        disp_sh  <= bus.display;
        dp_sh    <= bus.dp;
        blank_sh <= bus.blank_mask;
        blink_sh <= bus.blink_mask;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  seg_hex_decoder u_hex (
    .nibble (disp_sh[idx]),
    .seg    (hex_seg)
  );

  // Brightness and enable bypass the shadows so dimming reacts within the current slot.
  always_comb begin
    lit    = bus.enable && !blank_sh[idx] && (sub_phase <= bus.brightness)
             && !(blink_sh[idx] && blink_phase);
    en_nxt = '1;
    cx_nxt = SEG_OFF;
    if (lit) begin
      en_nxt[idx] = 1'b0;
      cx_nxt      = seg_pack(hex_seg, ~dp_sh[idx]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.led_en     <= '1;
      bus.led_cx     <= SEG_OFF;
      bus.frame_done <= 1'b0;
    end else begin
      bus.led_en     <= en_nxt;
      bus.led_cx     <= cx_nxt;
      bus.frame_done <= slot_tick && last_digit;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SP = 16;
  localparam int BH = 64;
  localparam int FRAME = SP * ND;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_PERIOD (SP),
    .BLINK_HALF  (BH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int total = 0;
  int bad   = 0;
  int k;  // rising edges since reset release

  logic [15:0]   m_disp;
  logic [ND-1:0] m_dp, m_blank, m_blink;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    m_disp  = '0;
    m_dp    = '0;
    m_blank = '0;
    m_blink = '0;
  endtask

  // One clock: predict from position in the scan (k) and the frame's captured inputs.
  task automatic step();
    int         d, sub;
    bit         lit, fd;
    logic [3:0] nib;
    logic [3:0] exp_en;
    logic [7:0] exp_cx;
    @(posedge clk);
    d   = (k / SP) % ND;
    sub = (k % SP) / (SP / 8);
    lit = bus.enable && !m_blank[d] && (sub <= int'(bus.brightness))
          && !(m_blink[d] && ((k / BH) % 2 == 1));
    nib    = m_disp[4*d +: 4];
    exp_en = lit ? ~(4'b0001 << d) : 4'hF;
    exp_cx = lit ? {hex_tab[nib], ~m_dp[d]} : 8'hFF;
    fd     = (k % FRAME) == FRAME - 1;
    if (fd) begin
      m_disp  = bus.display;
      m_dp    = bus.dp;
      m_blank = bus.blank_mask;
      m_blink = bus.blink_mask;
    end
    @(negedge clk);
    chk("led_en", 32'(bus.led_en), 32'(exp_en));
    chk("led_cx", 32'(bus.led_cx), 32'(exp_cx));
    chk("frame_done", 32'(bus.frame_done), 32'(fd));
    k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) bus.display    = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus.dp         = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.blank_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.blink_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.brightness = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) bus.enable    = ($urandom_range(0, 3) != 0);
      step();
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.enable     = 1'b1;
    bus.display    = 16'h1234;
    bus.dp         = '0;
    bus.blank_mask = '0;
    bus.blink_mask = '0;
    bus.brightness = 3'd7;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_led_en", 32'(bus.led_en), 32'hF);
    chk("rst_led_cx", 32'(bus.led_cx), 32'hFF);
    chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
    rst = 1'b0;

    // Full brightness; the first frame shows the zeroed shadows.
    run(3 * FRAME);
    bus.brightness = 3'd1;
    run(FRAME);
    bus.brightness = 3'd7;
    bus.blink_mask = 4'b0001;
    run(4 * FRAME);
    bus.blink_mask = 4'b0000;
    while (k % FRAME != 20) step();
    bus.display = 16'hABCD;
    run(2 * FRAME);
    bus.dp         = 4'b0100;
    bus.blank_mask = 4'b1000;
    run(2 * FRAME);
    bus.enable = 1'b0;
    run(FRAME);
    bus.enable = 1'b1;
    run_random(1500);

    // Reset in the middle of digit 2's slot.
    bus.blank_mask = '0;
    bus.blink_mask = '0;
    bus.brightness = 3'd7;
    bus.enable     = 1'b1;
    while (!((k % FRAME) / SP == 2 && (k % SP) == 5)) step();
    rst = 1'b1;
    #1;
    chk("midrst_led_en", 32'(bus.led_en), 32'hF);
    chk("midrst_led_cx", 32'(bus.led_cx), 32'hFF);
    chk("midrst_frame_done", 32'(bus.frame_done), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(2 * FRAME);
    run_random(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
